// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: instruction memory with a registered valid/ready fetch port,
// a program-load write port and per-fetch fault reporting.
// Optional build macro IMEM_PARITY_EN adds one even-parity bit per stored word.
// A fetch whose recomputed parity is wrong reports fault code 11.
module imem_fetch_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 64,
  parameter string             INIT_FILE = "",
  parameter logic [DATA_W-1:0] NOP_WORD  = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [1:0]        rsp_fault_o,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [DATA_W-1:0] prog_data_i,
  output logic              prog_err_o
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned WIDX_W = ADDR_W - 2;
  // Full-width word-index limit, so high address bits never alias into range.
  localparam logic [WIDX_W-1:0] DEPTH_W = WIDX_W'(DEPTH);

`ifdef IMEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  localparam logic [1:0] FLT_OK  = 2'b00;
  localparam logic [1:0] FLT_MIS = 2'b01;
  localparam logic [1:0] FLT_OOR = 2'b10;
`ifdef IMEM_PARITY_EN
  localparam logic [1:0] FLT_PAR = 2'b11;
`endif

  // Stored word format; with parity the extra MSB makes the whole word XOR to 0.
  function automatic logic [MEM_W-1:0] pack_word(input logic [DATA_W-1:0] d);
`ifdef IMEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [MEM_W-1:0]  mem_q [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        fault_q, fault_d;
  logic              prog_err_q;

  logic              accept;
  logic              misalign, oor;
  logic [IDX_W-1:0]  fidx, pidx;
  logic [MEM_W-1:0]  rd_word;
  logic              prog_ok;

  assign rsp_valid_o = (state_q == S_FULL);
  assign rsp_data_o  = data_q;
  assign rsp_fault_o = fault_q;
  assign prog_err_o  = prog_err_q;

  // A program write owns the cycle; otherwise accept when the output slot frees up.
  assign req_ready_o = !prog_we_i && (!rsp_valid_o || rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  assign misalign = |req_addr_i[1:0];
  assign oor      = (req_addr_i[ADDR_W-1:2] >= DEPTH_W);
  assign fidx     = req_addr_i[IDX_W+1:2];
  assign pidx     = prog_addr_i[IDX_W+1:2];
  assign prog_ok  = (prog_addr_i[1:0] == 2'b00) && (prog_addr_i[ADDR_W-1:2] < DEPTH_W);

  // Next response word and fault code for an accepted request (priority mis > oor > par).
  always_comb begin
    rd_word = '0;
    data_d  = NOP_WORD;
    fault_d = FLT_OK;
    if (misalign) begin
      fault_d = FLT_MIS;
    end else if (oor) begin
      fault_d = FLT_OOR;
    end else begin
      rd_word = mem_q[fidx];
`ifdef IMEM_PARITY_EN
      if (^rd_word) fault_d = FLT_PAR;
      else          data_d  = rd_word[DATA_W-1:0];
`else
      data_d = rd_word[DATA_W-1:0];
`endif
    end
  end

  // Output slot occupancy: fill on accept, drain on ready without refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL:  if (rsp_ready_i && !accept) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // Response register; holds data/fault stable until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
      fault_q <= FLT_OK;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q  <= data_d;
        fault_q <= fault_d;
      end
    end
  end

  // Program-port write into the array; dropped writes are flagged below.
  always_ff @(posedge clk) begin
    if (prog_we_i && prog_ok) mem_q[pidx] <= pack_word(prog_data_i);
  end

  // Sticky program error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    prog_err_q <= 1'b0;
    else if (prog_we_i && !prog_ok) prog_err_q <= 1'b1;
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit (default parameters).
// Expected responses are queued on accept and compared when the DUT hands them over.
module tb_imem_fetch_unit;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [31:0] req_addr_i, rsp_data_o, prog_addr_i, prog_data_i;
  logic [1:0]  rsp_fault_o;
  logic        prog_we_i, prog_err_o;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  fault;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] model [DEPTH];
  int          n_tests = 0;
  int          n_fail  = 0;

  imem_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_fault_o(rsp_fault_o),
    .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i), .prog_data_i(prog_data_i),
    .prog_err_o(prog_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_exp(input logic [31:0] a);
    exp_t e;
    if (a[1:0] != 2'b00)        e = '{data: NOP, fault: 2'b01};
    else if ((a >> 2) >= DEPTH) e = '{data: NOP, fault: 2'b10};
    else                        e = '{data: model[a[7:2]], fault: 2'b00};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_we_i = 1'b1; prog_addr_i = a; prog_data_i = d;
    tick();
    prog_we_i = 1'b0;
    if (a[1:0] == 2'b00 && (a >> 2) < DEPTH) model[a[7:2]] = d;
  endtask

  task automatic fetch_exp(input logic [31:0] a, input exp_t e);
    req_valid_i = 1'b1; req_addr_i = a;
    @(negedge clk);
    check("req_ready", {31'd0, req_ready_o}, 32'd1);
    if (req_ready_o) sb_q.push_back(e);
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_exp(a, model_exp(a));
  endtask

  // Scoreboard consumer: compare every handed-over response against the queue head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_o && rsp_ready_i) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_data", rsp_data_o, e.data);
        check("rsp_fault", {30'd0, rsp_fault_o}, {30'd0, e.fault});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid_i = 1'b0; req_addr_i = '0; rsp_ready_i = 1'b1;
    prog_we_i = 1'b0; prog_addr_i = '0; prog_data_i = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 'x;

    @(negedge clk);
    check("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_data", rsp_data_o, 32'd0);
    check("rst_fault", {30'd0, rsp_fault_o}, 32'd0);
    check("rst_perr", {31'd0, prog_err_o}, 32'd0);
    check("rst_ready", {31'd0, req_ready_o}, 32'd1);
    rst_n = 1'b1;
    tick();

    prog(32'h00, 32'h00000493);
    prog(32'h08, 32'h00A00293);
    prog(32'h20, 32'hFEDFF06F);
    prog(32'hFC, 32'h12345678);
    prog(32'h04, 32'h00000000);
    check("perr_clean", {31'd0, prog_err_o}, 32'd0);

    // single fetch, one-cycle latency, then drain
    fetch(32'h08);
    check("lat_valid", {31'd0, rsp_valid_o}, 32'd1);
    tick();
    check("drain_valid", {31'd0, rsp_valid_o}, 32'd0);

    // back-to-back
    fetch(32'h00);
    fetch(32'h20);
    tick();

    // stall: response held stable, no new accepts
    rsp_ready_i = 1'b0;
    fetch(32'h00);
    repeat (3) begin
      @(negedge clk);
      check("hold_ready", {31'd0, req_ready_o}, 32'd0);
      check("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("hold_data", rsp_data_o, 32'h00000493);
    end
    tick();
    rsp_ready_i = 1'b1;
    fetch(32'h08);
    tick();

    // fault decode and range boundaries
    fetch(32'h06);
    fetch(32'h100);
    fetch(32'h80000000);
    fetch(32'hFC);
    fetch(32'h04);
    tick();

    // dropped program writes
    prog(32'h102, 32'hDEADBEEF);
    check("perr_set", {31'd0, prog_err_o}, 32'd1);
    prog(32'h100, 32'hCAFEF00D);
    fetch(32'h00);
    tick();

    // prog_we blocks fetch
    prog_we_i = 1'b1; prog_addr_i = 32'h10; prog_data_i = 32'h00000055;
    req_valid_i = 1'b1; req_addr_i = 32'h00;
    @(negedge clk);
    check("block_ready", {31'd0, req_ready_o}, 32'd0);
    tick();
    prog_we_i = 1'b0; req_valid_i = 1'b0;
    model[4] = 32'h00000055;
    check("block_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    fetch(32'h10);
    tick();

    // reset while a response is pending
    rsp_ready_i = 1'b0;
    fetch(32'h20);
    check("pend_valid", {31'd0, rsp_valid_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rstmid_perr", {31'd0, prog_err_o}, 32'd0);
    check("rstmid_data", rsp_data_o, 32'd0);
    sb_q.delete();
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    fetch(32'h20);
    tick();

`ifdef IMEM_PARITY_EN
    dut.mem_q[2][0] <= ~dut.mem_q[2][0];
    tick();
    fetch_exp(32'h08, '{data: NOP, fault: 2'b11});
    fetch(32'h00);
    tick();
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
